// File: rtl/spectro_frame_scheduler.sv
// Periodic frame scheduler: a period timer launches frames of N_CH+1 words that are
// loaded from an external mux and shifted out MSB-first, with sticky overrun detection.
module spectro_frame_scheduler #(
    parameter  int N_CH     = 15,
    parameter  int WORD_W   = 12,
    parameter  int PERIOD_W = 16,
    localparam int SEL_W    = $clog2(N_CH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic [WORD_W-1:0]   word_in,
    input  logic                overrun_clr,
    output logic [SEL_W-1:0]    sel,
    output logic                load,
    output logic                sdata,
    output logic                sframe,
    output logic                clear_ch,
    output logic                busy,
    output logic                overrun,
    output logic [15:0]         frame_count
);
    localparam int               BIT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CLEAR
    } state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
    logic                overrun_q, overrun_d;
    logic [15:0]         fcount_q, fcount_d;
    logic [PERIOD_W-1:0] period_last;
    logic                tick;
    logic                in_frame;

    // A period of 0 behaves like 1: the terminal count is 0 and the timer ticks every cycle.
    assign period_last = (period == '0) ? '0 : (period - PERIOD_W'(1));
    assign tick        = enable && (timer_q == period_last);
    assign in_frame    = (state_q != S_IDLE);

    always_comb begin
        timer_d = timer_q + PERIOD_W'(1);
        if (!enable || tick) begin
            timer_d = '0;
        end
    end

    // A tick while a frame is in flight (CLEAR included) is dropped and flagged; set beats clear.
    always_comb begin
        overrun_d = overrun_q;
        if (tick && in_frame) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        fcount_d = fcount_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shreg_d  = word_in;
                bitcnt_d = '0;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                shreg_d  = shreg_q << 1;
                bitcnt_d = bitcnt_q + BIT_W'(1);
                if (bitcnt_q == LAST_BIT) begin
                    if (sel_q == LAST_SEL) begin
                        state_d = S_CLEAR;
                    end else begin
                        sel_d   = sel_q + SEL_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_CLEAR: begin
                fcount_d = fcount_q + 16'd1;
                sel_d    = '0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            sel_q     <= '0;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            overrun_q <= 1'b0;
            fcount_q  <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            sel_q     <= sel_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            overrun_q <= overrun_d;
            fcount_q  <= fcount_d;
        end
    end

    assign sel         = sel_q;
    assign load        = (state_q == S_LOAD);
    assign sframe      = (state_q == S_SHIFT);
    assign sdata       = (state_q == S_SHIFT) ? shreg_q[WORD_W-1] : 1'b0;
    assign clear_ch    = (state_q == S_CLEAR);
    assign busy        = in_frame;
    assign overrun     = overrun_q;
    assign frame_count = fcount_q;

endmodule

// File: tb/tb_spectro_frame_scheduler.sv
// Bench for spectro_frame_scheduler: a frame-offset reference model feeds a word/clear
// scoreboard and per-cycle expectations; directed scenarios plus a randomized soak.
module tb_spectro_frame_scheduler;
    localparam int N_CH     = 15;
    localparam int WORD_W   = 12;
    localparam int PERIOD_W = 16;
    localparam int SEL_W    = 4;
    localparam int SLOT     = WORD_W + 1;
    localparam int FRAME    = (N_CH + 1) * SLOT;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                enable = 1'b0;
    logic [PERIOD_W-1:0] period = '0;
    logic [WORD_W-1:0]   word_in;
    logic                overrun_clr = 1'b0;
    logic [SEL_W-1:0]    sel;
    logic                load, sdata, sframe, clear_ch, busy, overrun;
    logic [15:0]         frame_count;

    logic [WORD_W-1:0]   tab [0:N_CH];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_comb word_in = tab[sel];

    spectro_frame_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .period      (period),
        .word_in     (word_in),
        .overrun_clr (overrun_clr),
        .sel         (sel),
        .load        (load),
        .sdata       (sdata),
        .sframe      (sframe),
        .clear_ch    (clear_ch),
        .busy        (busy),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a tick cycle plus an offset; everything follows from offset.
    int  cyc = 0;
    int  m_timer = 0;
    int  m_start = 0;
    int  m_fc = 0;
    int  m_eff;
    bit  m_tk;
    bit  m_active = 1'b0;
    bit  m_ovr = 1'b0;
    bit  e_busy, e_load, e_sframe, e_clear;
    int  e_sel;
    logic [WORD_W-1:0] wq[$];
    int  cq[$];

    function automatic void disp(input int c);
        int r;
        r        = c - m_start;
        e_busy   = m_active && (r >= 1) && (r <= FRAME + 1);
        e_load   = e_busy && (r <= FRAME) && (((r - 1) % SLOT) == 0);
        e_sframe = e_busy && (r <= FRAME) && (((r - 1) % SLOT) != 0);
        e_clear  = e_busy && (r == FRAME + 1);
        e_sel    = e_busy ? (((r - 1) / SLOT > N_CH) ? N_CH : (r - 1) / SLOT) : 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            cyc = 0; m_timer = 0; m_start = 0; m_fc = 0;
            m_active = 1'b0; m_ovr = 1'b0;
            wq.delete(); cq.delete();
            disp(0);
        end else begin
            m_eff = (period == '0) ? 1 : int'(period);
            m_tk  = enable && (m_timer == m_eff - 1);
            disp(cyc);
            if (e_load) wq.push_back(tab[e_sel]);
            if (e_clear) m_fc = (m_fc + 1) % 65536;
            if (m_tk && e_busy) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
            if (m_tk && !e_busy) begin
                m_active = 1'b1;
                m_start  = cyc;
                cq.push_back(cyc + FRAME + 1);
            end
            m_timer = (!enable || m_tk) ? 0 : (m_timer + 1) % 65536;
            cyc++;
            disp(cyc);
        end
    end

    // Monitor: per-cycle expectations plus scoreboard pops for each finished word and clear.
    logic [WORD_W-1:0] acc = '0;
    logic [WORD_W-1:0] first_word = '0;
    bit  got_first = 1'b0;
    int  nb = 0;
    int  load_total = 0;
    int  load_cycs[$];
    int  clr_cycs[$];

    always @(negedge clk) begin
        if (reset) begin
            nb  = 0;
            acc = '0;
        end else begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("load", 32'(load), 32'(e_load));
            chk("sframe", 32'(sframe), 32'(e_sframe));
            chk("clear_ch", 32'(clear_ch), 32'(e_clear));
            chk("sel", 32'(sel), e_sel);
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("frame_count", 32'(frame_count), m_fc);
            if (!sframe) chk("sdata_idle", 32'(sdata), 0);
            if (load) begin
                load_total++;
                nb = 0;
                if (sel == '0) load_cycs.push_back(cyc);
            end
            if (sframe) begin
                acc = {acc[WORD_W-2:0], sdata};
                nb++;
                if (nb == WORD_W) begin
                    chk("word_expected", 32'(wq.size() != 0), 1);
                    if (wq.size() != 0) chk("word", 32'(acc), 32'(wq.pop_front()));
                    if (!got_first) begin
                        first_word = acc;
                        got_first  = 1'b1;
                    end
                    nb = 0;
                end
            end
            if (clear_ch) begin
                clr_cycs.push_back(cyc);
                chk("clear_expected", 32'(cq.size() != 0), 1);
                if (cq.size() != 0) chk("clear_cycle", cyc, cq.pop_front());
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        load_cycs.delete();
        clr_cycs.delete();
        load_total = 0;
        got_first  = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        chk("cycle_reached", cyc, n);
    endtask

    task automatic rand_tab();
        for (int k = 0; k <= N_CH; k++) tab[k] = WORD_W'($urandom);
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit seen;
        int n0;

        // Nominal frame, period 300, word k = 0xA00 + k.
        for (int k = 0; k <= N_CH; k++) tab[k] = 12'hA00 + WORD_W'(k);
        period = 16'd300;
        enable = 1'b1;
        do_reset();
        wait_cyc(300);
        chk("load_at_300", 32'(load), 1);
        wait_cyc(560);
        chk("frame_starts", 32'(load_cycs.size()), 1);
        chk("first_load_cycle", q_at(load_cycs, 0), 300);
        chk("first_word_bits", 32'(first_word), 32'(12'b101000000000));
        chk("clear_pulses", 32'(clr_cycs.size()), 1);
        chk("clear_cycle_508", q_at(clr_cycs, 0), 508);
        chk("frame_count_1", 32'(frame_count), 1);
        chk("no_overrun", 32'(overrun), 0);

        // Period shortened to 100 after the first tick: busy tick at 399, restart at 599.
        rand_tab();
        period = 16'd300;
        do_reset();
        wait_cyc(300);
        period = 16'd100;
        wait_cyc(399);
        chk("ovr_before_399", 32'(overrun), 0);
        wait_cyc(400);
        chk("ovr_after_399", 32'(overrun), 1);
        chk("busy_400", 32'(busy), 1);
        wait_cyc(650);
        overrun_clr = 1'b1;
        wait_cyc(651);
        overrun_clr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 0);
        wait_cyc(699);
        overrun_clr = 1'b1;
        wait_cyc(700);
        overrun_clr = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 1);
        chk("two_frames", 32'(load_cycs.size()), 2);
        chk("second_load_600", q_at(load_cycs, 1), 600);
        chk("first_clear_508", q_at(clr_cycs, 0), 508);

        // Enable dropped on the 50th shift cycle.
        rand_tab();
        period = 16'($urandom_range(20, 80));
        enable = 1'b1;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 2000 && cnt < 50; i++) begin
            @(negedge clk);
            if (sframe) cnt++;
        end
        chk("shift_50_reached", cnt, 50);
        enable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (clear_ch) seen = 1'b1;
        end
        chk("clear_after_disable", 32'(seen), 1);
        n0 = load_total;
        repeat (1000) @(negedge clk);
        chk("no_load_when_disabled", load_total - n0, 0);
        chk("timer_held_zero", 32'(dut.timer_q), 0);
        chk("frame_count_disable", 32'(frame_count), 1);

        // Reset at word 7, bit 5.
        rand_tab();
        period = 16'($urandom_range(5, 50));
        enable = 1'b1;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (sframe && sel == 4'd7) seen = 1'b1;
        end
        chk("word7_reached", 32'(seen), 1);
        repeat (5) @(negedge clk);
        chk("pre_reset_sframe", 32'(sframe), 1);
        reset = 1'b1;
        #1;
        chk("rst_sel", 32'(sel), 0);
        chk("rst_load", 32'(load), 0);
        chk("rst_sdata", 32'(sdata), 0);
        chk("rst_sframe", 32'(sframe), 0);
        chk("rst_clear_ch", 32'(clear_ch), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_frame_count", 32'(frame_count), 0);
        enable = 1'b0;
        do_reset();
        repeat (50) @(negedge clk);
        chk("no_clear_after_reset", 32'(clr_cycs.size()), 0);
        chk("frame_count_after_reset", 32'(frame_count), 0);

        // Period 0: back-to-back frames every FRAME+2 cycles.
        rand_tab();
        period = '0;
        enable = 1'b1;
        do_reset();
        wait_cyc(1);
        chk("p0_ovr_cycle1", 32'(overrun), 0);
        wait_cyc(2);
        chk("p0_ovr_cycle2", 32'(overrun), 1);
        wait_cyc(640);
        chk("p0_clears", 32'(clr_cycs.size()), 3);
        chk("p0_first_clear", q_at(clr_cycs, 0), 209);
        chk("p0_spacing_1", q_at(clr_cycs, 1) - q_at(clr_cycs, 0), 210);
        chk("p0_spacing_2", q_at(clr_cycs, 2) - q_at(clr_cycs, 1), 210);
        chk("p0_frame_count", 32'(frame_count), 3);

        // Randomized soak: live period changes, enable toggles, clears, changing mux data.
        rand_tab();
        period = 16'($urandom_range(30, 200));
        enable = 1'b1;
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            rand_tab();
            overrun_clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 299) == 0) period = 16'($urandom_range(0, 350));
            if ($urandom_range(0, 499) == 0) enable = ~enable;
        end
        overrun_clr = 1'b0;
        enable = 1'b0;
        repeat (260) @(negedge clk);
        chk("words_drained", 32'(wq.size()), 0);
        chk("clears_drained", 32'(cq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spectro_frame_scheduler.md
Name: spectro_frame_scheduler

Overview:
Periodic frame scheduler for the spectrogram serial output path. A programmable period timer starts each frame. For each word of the frame (timestamp word, then channels 1..N_CH), the block drives the word-select lines to the external data mux, loads the selected word and shifts it out MSB-first. After the last word it pulses a clear to the channel counters. It also flags an overrun when a period elapses while a frame is still being sent.

Parameters:
N_CH, 15, number of channel words per frame; word 0 is the timestamp/RTC word.
WORD_W, 12, bits per word.
PERIOD_W, 16, width of the period register and the timer.
SEL_W, $clog2(N_CH+1) (4 at default), width of sel; localparam, not overridable.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high; returns all state and outputs to reset values.
enable  in  1  1 = period timer runs; 0 = timer held at 0 and no new frames start.
period  in  PERIOD_W  frame period in clk cycles, sampled live; 0 and 1 both mean a tick every cycle.
word_in  in  WORD_W  data from the external mux, selected by sel; must be stable combinationally in the same cycle.
overrun_clr  in  1  single-cycle pulse that clears overrun.
sel  out  SEL_W  registered word select; 0 = RTC, k = channel k.
load  out  1  high during the LOAD cycle (the shift register captures word_in).
sdata  out  1  serial data, MSB first; 0 outside SHIFT.
sframe  out  1  high on every cycle where sdata carries a valid bit.
clear_ch  out  1  one-cycle pulse that resets the channel counters at the end of a frame.
busy  out  1  high in any state other than IDLE.
overrun  out  1  sticky; set when a tick occurs while busy.
frame_count  out  16  number of completed frames, wraps at 2^16.

Behaviour:
- Reset values: state IDLE, timer 0, sel 0, load 0, sdata 0, sframe 0, clear_ch 0, busy 0, overrun 0, frame_count 0, shift register 0, bit counter 0.
- Timer:
  - enable=1: counts 0..max(period,1)-1 and then wraps to 0.
  - tick = enable and (timer == max(period,1)-1), combinational.
  - enable=0: timer is forced to 0 and tick=0.
- State machine (all transitions registered):
  - IDLE: sel=0. On tick, go to LOAD.
  - LOAD (1 cycle): load=1, shreg <= word_in, bitcnt <= 0, go to SHIFT.
  - SHIFT (WORD_W cycles): sdata = shreg[WORD_W-1], sframe=1, shreg shifts left each cycle, bitcnt increments.
    - On bitcnt == WORD_W-1 and sel == N_CH, go to CLEAR.
    - On bitcnt == WORD_W-1 otherwise, sel <= sel+1 and go to LOAD.
  - CLEAR (1 cycle): clear_ch=1, frame_count++, sel <= 0, go to IDLE.
- Frame length: (N_CH+1)*(WORD_W+1) cycles from LOAD entry to CLEAR entry, which is 208 at defaults. sframe is low during each LOAD gap cycle.
- Latency: tick in cycle t gives LOAD in t+1, first data bit in t+2, CLEAR in t+209 and IDLE in t+210 (defaults).
- Overrun:
  - A tick in any state other than IDLE sets overrun and the tick is dropped; the frame in progress is not disturbed.
  - A tick in the CLEAR cycle counts as busy: it is dropped and sets overrun.
  - overrun_clr clears overrun. If set and clear occur in the same cycle, set wins.
- enable deasserted mid-frame: the current frame completes normally; only new ticks stop.
- period changed mid-count:
  - If the new period is above the current timer value, the timer ticks when it reaches the new max(period,1)-1.
  - If the new period is at or below the current timer value, the timer continues counting up and wraps at 2^PERIOD_W. This is documented, not an error.
- reset asserted mid-frame: immediate return to reset values; no clear_ch pulse is issued.
- sel changes only on the LOAD-bound transition out of SHIFT and in CLEAR, so it is stable for the whole LOAD cycle.

Test Plan:
- Reset, enable=1, period=300, word_in = 0xA00 + sel. Required:
  - first tick at cycle 299, LOAD at 300;
  - sdata stream of word0 = 101000000000;
  - 16 words received in order, values 0xA00..0xA0F;
  - clear_ch pulses once, 209 cycles after the tick;
  - frame_count = 1, overrun = 0.
- Same setup, period=100. Required: second tick at busy cycle 399 sets overrun, no restart mid-frame, next frame starts at tick 599. Then pulse overrun_clr: overrun returns to 0.
- overrun_clr asserted in the same cycle as a busy tick: overrun remains 1.
- enable dropped at the 50th SHIFT cycle: frame completes with clear_ch; no further LOAD for 1000 cycles; timer reads 0.
- reset asserted at word 7, bit 5: all outputs return to reset values the same cycle; clear_ch stays 0; frame_count is unchanged at 0.
- period=0 with enable=1: frames run back-to-back, overrun is set by the tick one cycle after the first, and frame_count increments every 210 cycles.
